clint_trap_ctrl: RTL
====================

CLINT_TRAP_CTRL -- requirements
Module: clint_trap_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning width of every CSR data and PC bus.
REQ-002 SHALL have ports as follows (clock and reset first):
- Clk  in  1  sole clock; all state updates on its rising edge.
- Rst  in  1  reset, synchronous, active-high.
- EcallIn  in  1  ecall retiring at Wb.
- MretIn  in  1  mret retiring at Wb.
- InstAddrIn  in  DATA_W  PC of the instruction at Wb.
- NextPcIn  in  DATA_W  PC of the next instruction to execute.
- ExtIrqIn, SwIrqIn, TimerIrqIn  in  1 each  level-sensitive interrupt lines.
- CsrMstatusReadDataIn, CsrMtvecReadDataIn, CsrMepcReadDataIn, CsrMieReadDataIn  in  DATA_W each  live CSR values.
- CsrWriteEnableWbIn  in  1  pipeline CSR write active this cycle.
- CsrWriteDataClintOut  out  DATA_W  CSR write data.
- CsrWriteAddrClintOut  out  12  CSR write address.
- CsrWriteEnableClintOut  out  1  CSR write strobe.
- HoldOut  out  1  stall pipeline.
- FlushOut  out  1  flush pipeline.
- RedirectValidOut  out  1  PC redirect strobe.
- RedirectPcOut  out  DATA_W  redirect target.

Function
REQ-003 SHALL implement an FSM with states IDLE, SAVE_MEPC, SAVE_MCAUSE, SAVE_MSTATUS, TRAP_JUMP, MRET_RESTORE, MRET_JUMP.
REQ-004 SHALL, in IDLE, evaluate events each cycle in priority order: EcallIn > MretIn > ExtIrqIn > SwIrqIn > TimerIrqIn; exactly one event is accepted per cycle.
REQ-005 SHALL take an interrupt only if mstatus[3] (MIE)=1 and the matching mie bit is 1: ext bit 11, sw bit 3, timer bit 7; masked lines are ignored.
REQ-006 SHALL, on an accepted trap, latch cause and EPC in the IDLE cycle: ecall -> cause 11, EPC=InstAddrIn; ext -> {1'b1, 11}, sw -> {1'b1, 3}, timer -> {1'b1, 7}, EPC=NextPcIn; then go to SAVE_MEPC.
REQ-007 SHALL, on an accepted mret, go to MRET_RESTORE.
REQ-008 SHALL, in SAVE_MEPC, SAVE_MCAUSE, SAVE_MSTATUS and MRET_RESTORE, drive CsrWriteEnableClintOut=1 only when CsrWriteEnableWbIn=0; if CsrWriteEnableWbIn=1, SHALL drive strobe 0 and remain in the state.
REQ-009 SHALL write 0x341 with latched EPC in SAVE_MEPC, then write 0x342 with latched cause in SAVE_MCAUSE.
REQ-010 SHALL, in SAVE_MSTATUS, write 0x300 with the live mstatus modified as follows: bit7 (MPIE)=old bit3; bit3=0; bits12:11 (MPP)=2'b11; all other bits unchanged.
REQ-011 SHALL, in MRET_RESTORE, write 0x300 with the live mstatus modified as follows: bit3=old bit7; bit7=1; all other bits unchanged.
REQ-012 SHALL, in each write state, advance to the next state in the cycle the write strobe is 1.
REQ-013 SHALL, in TRAP_JUMP, drive RedirectValidOut=1, FlushOut=1, RedirectPcOut = mtvec with bits[1:0] cleared, for one cycle, then return to IDLE.
REQ-014 SHALL, in MRET_JUMP, drive RedirectValidOut=1, FlushOut=1, RedirectPcOut=CsrMepcReadDataIn, for one cycle, then return to IDLE.
REQ-015 SHALL drive HoldOut=1 in every state except IDLE.
REQ-016 SHALL hold outputs at 0 whenever they are not asserted by REQ-008 to REQ-015.
REQ-017 SHALL complete an uncontended trap in 5 cycles (accept in IDLE, 3 writes, jump) and an uncontended mret in 3 cycles.
REQ-018 SHALL ignore interrupt, ecall and mret inputs outside IDLE; they are not queued.

Reset
REQ-019 SHALL, on Rst=1 at a rising edge, enter IDLE, clear latched cause and EPC, and drive every output to 0, including when a sequence is in progress.
REQ-020 SHALL give Rst priority over every event in the same cycle.

Verification
REQ-021 Scenario: mstatus=0x8, mie=0x800, ExtIrqIn=1, NextPcIn=0x1000, mtvec=0x2001 -> writes 0x341=0x1000, 0x342=0x8000_0000_0000_000B, 0x300=0x1880; redirect to 0x2000 on cycle 5.
REQ-022 Scenario: ecall with InstAddrIn=0x400 while CsrWriteEnableWbIn=1 for 2 cycles in SAVE_MEPC -> no strobe for those 2 cycles; 0x341=0x400 written after; HoldOut stays 1 throughout.
REQ-023 Scenario: mstatus=0x1880, mepc=0x1000, MretIn=1 -> 0x300=0x1888 written; redirect to 0x1000; sequence takes 3 cycles.
REQ-024 Scenario: TimerIrqIn and SwIrqIn both 1, with mie=0x88 and MIE=1 -> cause {1,3}; with MIE=0 -> no action and HoldOut=0.
REQ-025 Scenario: Rst=1 during SAVE_MCAUSE -> next cycle IDLE, all outputs 0, no further CSR writes.
REQ-026 Scenario: EcallIn and MretIn both 1 in IDLE -> ecall trap sequence runs and mret is dropped.

Source files
------------

// File: rtl/clint_trap_ctrl.sv
// Machine-mode trap sequencer: accepts ecall, mret and masked interrupts at Wb,
// then updates mepc/mcause/mstatus over the CSR write port and redirects the PC.
module clint_trap_ctrl #(
    parameter int DATA_W = 64
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              EcallIn,
    input  logic              MretIn,
    input  logic [DATA_W-1:0] InstAddrIn,
    input  logic [DATA_W-1:0] NextPcIn,
    input  logic              ExtIrqIn,
    input  logic              SwIrqIn,
    input  logic              TimerIrqIn,
    input  logic [DATA_W-1:0] CsrMstatusReadDataIn,
    input  logic [DATA_W-1:0] CsrMtvecReadDataIn,
    input  logic [DATA_W-1:0] CsrMepcReadDataIn,
    input  logic [DATA_W-1:0] CsrMieReadDataIn,
    input  logic              CsrWriteEnableWbIn,
    output logic [DATA_W-1:0] CsrWriteDataClintOut,
    output logic [11:0]       CsrWriteAddrClintOut,
    output logic              CsrWriteEnableClintOut,
    output logic              HoldOut,
    output logic              FlushOut,
    output logic              RedirectValidOut,
    output logic [DATA_W-1:0] RedirectPcOut
);
    typedef enum logic [2:0] {
        IDLE, SAVE_MEPC, SAVE_MCAUSE, SAVE_MSTATUS, TRAP_JUMP, MRET_RESTORE, MRET_JUMP
    } state_t;

    localparam logic [DATA_W-1:0] IRQ_FLAG = {1'b1, {(DATA_W-1){1'b0}}};

    state_t            state;
    logic [DATA_W-1:0] causeQ;
    logic [DATA_W-1:0] epcQ;
    logic              globalIe;
    logic              extTake;
    logic              swTake;
    logic              timerTake;
    logic              writeGo;
    logic [DATA_W-1:0] trapStatus;
    logic [DATA_W-1:0] mretStatus;
    logic              unusedInputBits;

    assign globalIe  = CsrMstatusReadDataIn[3];
    assign extTake   = ExtIrqIn   & globalIe & CsrMieReadDataIn[11];
    assign swTake    = SwIrqIn    & globalIe & CsrMieReadDataIn[3];
    assign timerTake = TimerIrqIn & globalIe & CsrMieReadDataIn[7];
    assign unusedInputBits = ^{CsrMieReadDataIn, CsrMtvecReadDataIn[1:0]};

    // A write state may only use the CSR port when the pipeline is not writing.
    always_comb begin
        writeGo = 1'b0;
        if (state == SAVE_MEPC || state == SAVE_MCAUSE ||
            state == SAVE_MSTATUS || state == MRET_RESTORE)
            writeGo = ~CsrWriteEnableWbIn;
    end

    always_comb begin
        trapStatus        = CsrMstatusReadDataIn;
        trapStatus[7]     = CsrMstatusReadDataIn[3];
        trapStatus[3]     = 1'b0;
        trapStatus[12:11] = 2'b11;
        mretStatus        = CsrMstatusReadDataIn;
        mretStatus[3]     = CsrMstatusReadDataIn[7];
        mretStatus[7]     = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state  <= IDLE;
            causeQ <= '0;
            epcQ   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (EcallIn) begin
                        causeQ <= DATA_W'(11);
                        epcQ   <= InstAddrIn;
                        state  <= SAVE_MEPC;
                    end else if (MretIn) begin
                        state  <= MRET_RESTORE;
                    end else if (extTake) begin
                        causeQ <= IRQ_FLAG | DATA_W'(11);
                        epcQ   <= NextPcIn;
                        state  <= SAVE_MEPC;
                    end else if (swTake) begin
                        causeQ <= IRQ_FLAG | DATA_W'(3);
                        epcQ   <= NextPcIn;
                        state  <= SAVE_MEPC;
                    end else if (timerTake) begin
                        causeQ <= IRQ_FLAG | DATA_W'(7);
                        epcQ   <= NextPcIn;
                        state  <= SAVE_MEPC;
                    end
                end
                SAVE_MEPC:    if (writeGo) state <= SAVE_MCAUSE;
                SAVE_MCAUSE:  if (writeGo) state <= SAVE_MSTATUS;
                SAVE_MSTATUS: if (writeGo) state <= TRAP_JUMP;
                MRET_RESTORE: if (writeGo) state <= MRET_JUMP;
                default:      state <= IDLE;
            endcase
        end
    end

    // Write data/address are qualified by the strobe so stalled cycles read as zero.
    always_comb begin
        CsrWriteDataClintOut   = '0;
        CsrWriteAddrClintOut   = 12'h000;
        CsrWriteEnableClintOut = writeGo;
        HoldOut                = (state != IDLE);
        FlushOut               = 1'b0;
        RedirectValidOut       = 1'b0;
        RedirectPcOut          = '0;
        case (state)
            SAVE_MEPC: if (writeGo) begin
                CsrWriteAddrClintOut = 12'h341;
                CsrWriteDataClintOut = epcQ;
            end
            SAVE_MCAUSE: if (writeGo) begin
                CsrWriteAddrClintOut = 12'h342;
                CsrWriteDataClintOut = causeQ;
            end
            SAVE_MSTATUS: if (writeGo) begin
                CsrWriteAddrClintOut = 12'h300;
                CsrWriteDataClintOut = trapStatus;
            end
            MRET_RESTORE: if (writeGo) begin
                CsrWriteAddrClintOut = 12'h300;
                CsrWriteDataClintOut = mretStatus;
            end
            TRAP_JUMP: begin
                FlushOut         = 1'b1;
                RedirectValidOut = 1'b1;
                RedirectPcOut    = {CsrMtvecReadDataIn[DATA_W-1:2], 2'b00};
            end
            MRET_JUMP: begin
                FlushOut         = 1'b1;
                RedirectValidOut = 1'b1;
                RedirectPcOut    = CsrMepcReadDataIn;
            end
            default: ;
        endcase
    end
endmodule
